// File: rtl/risc24_mem_responder_pkg.sv
// Shared definitions for the RISC24 memory responder: word width, FSM encodings,
// the read data returned on a bus error, and the address range test.
package risc24_mem_responder_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam logic [WORD_W-1:0] BUS_ERR_RDATA = '0;

    // Any set bit above the implemented word-address range is a bus error.
    function automatic logic addr_out_of_range(input logic [WORD_W-1:0] a,
                                               input int unsigned       aw);
        return (a >> aw) != '0;
    endfunction

endpackage

// File: rtl/risc24_word_ram.sv
// Unified single-port word RAM: synchronous write, asynchronous read.
// The write port is shared between the preload port and the core write.
module risc24_word_ram
    import risc24_mem_responder_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              ld_en_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [WORD_W-1:0] ld_data_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];

    logic              mem_we_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [WORD_W-1:0] mem_data_d;

    // The two sources are never active together; the core write wins anyway.
    always_comb begin
        mem_we_d   = 1'b0;
        mem_addr_d = ld_addr_i;
        mem_data_d = ld_data_i;
        if (wr_en_i) begin
            mem_we_d   = 1'b1;
            mem_addr_d = wr_addr_i;
            mem_data_d = wr_data_i;
        end else if (ld_en_i) begin
            mem_we_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we_d) begin
            mem_q[mem_addr_d] <= mem_data_d;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/risc24_mem_responder.sv
// Memory-side responder for the RISC24 core bus: req/ack word reads and writes
// with programmable wait states, plus a side-band preload port.
module risc24_mem_responder
    import risc24_mem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [WORD_W-1:0] addr,
    input  logic              we,
    input  logic [WORD_W-1:0] wdata,
    output logic              ack,
    output logic [WORD_W-1:0] rdata,
    output logic              err,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [WORD_W-1:0] load_data,
    output logic              busy
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;

    logic [WORD_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              ram_ld;
    logic              ram_wr;
    logic              oor;
    logic [WORD_W-1:0] ram_rdata;

    assign oor = addr_out_of_range(addr_q, ADDR_W);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        ram_ld  = 1'b0;
        ram_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A preload steals the cycle; a pending req waits for the next one.
                if (load_en) begin
                    ram_ld = 1'b1;
                end else if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_INIT == 4'd0) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                ack_d   = 1'b1;
                state_d = S_IDLE;
                if (oor) begin
                    err_d   = 1'b1;
                    rdata_d = BUS_ERR_RDATA;
                end else if (we_q) begin
                    ram_wr = 1'b1;
                end else begin
                    rdata_d = ram_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Captured request fields are only meaningful while a transaction is open.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        we_q    <= we_d;
        wdata_q <= wdata_d;
    end

    risc24_word_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .ld_en_i   (ram_ld),
        .ld_addr_i (load_addr),
        .ld_data_i (load_data),
        .wr_en_i   (ram_wr),
        .wr_addr_i (addr_q[ADDR_W-1:0]),
        .wr_data_i (wdata_q),
        .rd_addr_i (addr_q[ADDR_W-1:0]),
        .rd_data_o (ram_rdata)
    );

    assign ack   = ack_q;
    assign err   = err_q;
    assign rdata = rdata_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_risc24_mem_responder.sv
// Directed bench for risc24_mem_responder: a WAIT_CYCLES=1 instance driven from
// a transaction table plus corner sequences, and a WAIT_CYCLES=0 instance.
module tb_risc24_mem_responder;

    logic        clk = 1'b0;
    logic        reset;

    logic        req1, we1, ack1, err1, busy1, load_en1;
    logic [15:0] addr1, wdata1, rdata1, load_data1;
    logic [7:0]  load_addr1;

    logic        req0, we0, ack0, err0, busy0, load_en0;
    logic [15:0] addr0, wdata0, rdata0, load_data0;
    logic [7:0]  load_addr0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    risc24_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .req(req1), .addr(addr1), .we(we1), .wdata(wdata1),
        .ack(ack1), .rdata(rdata1), .err(err1), .load_en(load_en1),
        .load_addr(load_addr1), .load_data(load_data1), .busy(busy1)
    );

    risc24_mem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .req(req0), .addr(addr0), .we(we0), .wdata(wdata0),
        .ack(ack0), .rdata(rdata0), .err(err0), .load_en(load_en0),
        .load_addr(load_addr0), .load_data(load_data0), .busy(busy0)
    );

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic load1(input logic [7:0] a, input logic [15:0] d);
        load_en1 = 1'b1; load_addr1 = a; load_data1 = d;
        @(posedge clk); #1;
        load_en1 = 1'b0;
    endtask

    task automatic load0(input logic [7:0] a, input logic [15:0] d);
        load_en0 = 1'b1; load_addr0 = a; load_data0 = d;
        @(posedge clk); #1;
        load_en0 = 1'b0;
    endtask

    // One transaction on dut1; starts and ends 1 time unit after a rising edge.
    task automatic txn1(input string nm, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [15:0] er, input logic ee);
        int lat;
        req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
        @(posedge clk); #1;
        lat = 0;
        while (!ack1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        req1 = 1'b0; we1 = 1'b0;
        check({nm, " ack"}, 32'(ack1), 32'd1);
        check({nm, " latency"}, 32'(lat), 32'd2);
        check({nm, " rdata"}, 32'(rdata1), 32'(er));
        check({nm, " err"}, 32'(err1), 32'(ee));
        @(posedge clk); #1;
        check({nm, " ack pulse"}, 32'(ack1), 32'd0);
        check({nm, " err clear"}, 32'(err1), 32'd0);
    endtask

    initial begin
        int lat;
        int nack;

        vecs[0]  = '{1'b0, 16'h0000, 16'h0000, 16'h22a1, 1'b0};
        vecs[1]  = '{1'b0, 16'h0001, 16'h0000, 16'h2849, 1'b0};
        vecs[2]  = '{1'b1, 16'h0010, 16'hbeef, 16'h2849, 1'b0};
        vecs[3]  = '{1'b0, 16'h0010, 16'h0000, 16'hbeef, 1'b0};
        vecs[4]  = '{1'b1, 16'h0011, 16'h1234, 16'hbeef, 1'b0};
        vecs[5]  = '{1'b0, 16'h0100, 16'h0000, 16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 16'h0100, 16'hdead, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 16'h22a1, 1'b0};
        vecs[8]  = '{1'b0, 16'h0011, 16'h0000, 16'h1234, 1'b0};
        vecs[9]  = '{1'b0, 16'h8001, 16'h0000, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 16'h0001, 16'h0000, 16'h2849, 1'b0};

        reset = 1'b1;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0; load_en1 = 0; load_addr1 = 0; load_data1 = 0;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; load_en0 = 0; load_addr0 = 0; load_data0 = 0;
        @(posedge clk); @(posedge clk); #1;
        check("reset ack", 32'(ack1), 32'd0);
        check("reset err", 32'(err1), 32'd0);
        check("reset rdata", 32'(rdata1), 32'd0);
        check("reset busy", 32'(busy1), 32'd0);
        check("reset busy w0", 32'(busy0), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Preload and table-driven transactions (WAIT_CYCLES=1)
        load1(8'h00, 16'h22a1);
        load1(8'h01, 16'h2849);
        for (int i = 0; i < 11; i++) begin
            txn1($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Reset during BUSY of a write aborts it
        load1(8'h20, 16'h0bad);
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h5555;
        @(posedge clk); #1;
        check("abort busy before", 32'(busy1), 32'd1);
        reset = 1'b1;
        #1;
        check("abort busy after", 32'(busy1), 32'd0);
        check("abort ack", 32'(ack1), 32'd0);
        check("abort rdata", 32'(rdata1), 32'd0);
        req1 = 1'b0; we1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        nack = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (ack1) nack++;
        end
        check("abort no ack", 32'(nack), 32'd0);
        txn1("abort ram20", 1'b0, 16'h0020, 16'h0000, 16'h0bad, 1'b0);
        txn1("abort ram0", 1'b0, 16'h0000, 16'h0000, 16'h22a1, 1'b0);

        // load_en while busy is ignored
        load1(8'h30, 16'h1111);
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0031;
        @(posedge clk); #1;
        check("busyload busy", 32'(busy1), 32'd1);
        load_en1 = 1'b1; load_addr1 = 8'h30; load_data1 = 16'h9999;
        @(posedge clk); #1;
        load_en1 = 1'b0;
        @(posedge clk); #1;
        check("busyload ack", 32'(ack1), 32'd1);
        req1 = 1'b0;
        @(posedge clk); #1;
        txn1("busyload ram30", 1'b0, 16'h0030, 16'h0000, 16'h1111, 1'b0);

        // load_en and req together in IDLE: load first, then the read
        load_en1 = 1'b1; load_addr1 = 8'h40; load_data1 = 16'h4444;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
        @(posedge clk); #1;
        load_en1 = 1'b0;
        check("loadreq idle", 32'(busy1), 32'd0);
        lat = 0;
        while (!ack1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        req1 = 1'b0;
        check("loadreq latency", 32'(lat), 32'd3);
        check("loadreq rdata", 32'(rdata1), 32'h4444);
        @(posedge clk); #1;

        // WAIT_CYCLES=0 instance
        load0(8'h00, 16'h22a1);
        load0(8'h01, 16'h2849);
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
        @(posedge clk); #1;
        check("w0 ack early", 32'(ack0), 32'd0);
        check("w0 busy", 32'(busy0), 32'd1);
        @(posedge clk); #1;
        req0 = 1'b0;
        check("w0 ack", 32'(ack0), 32'd1);
        check("w0 rdata", 32'(rdata0), 32'h22a1);
        @(posedge clk); #1;
        check("w0 ack pulse", 32'(ack0), 32'd0);

        req0 = 1'b1; addr0 = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check($sformatf("w0 b2b ack%0d", i), 32'(ack0), 32'(i % 2));
            if (ack0) check($sformatf("w0 b2b rdata%0d", i), 32'(rdata0), 32'h2849);
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("w0 final idle", 32'(busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
